dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data-cache controller sitting between the CPU load/store port and the block-oriented DataMem.
- Serves read hits from local line storage. Fetches a 4-word (128-bit) block from DataMem on a read miss. Forwards every store to DataMem.
- Holds the CPU with a stall signal until the DataMem `ready` handshake completes.

Parameters:
- ADDR_W, 10, word address width; matches DataMem `addr`.
- INDEX_W, 4, line index bits (16 lines). Tag width = ADDR_W-INDEX_W-2 (4 by default).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_read  in  1  load request, level-held while stall=1.
- cpu_write  in  1  store request, level-held while stall=1.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_read=1 and stall=0.
- stall  out  1  CPU must hold its request while high.
- mem_read  out  1  to DataMem MemRead.
- mem_write  out  1  to DataMem MemWrite.
- mem_addr  out  ADDR_W  to DataMem addr.
- mem_wdata  out  32  to DataMem data_in.
- mem_block  in  128  from DataMem data_out; word k at bits [32k+31:32k].
- mem_ready  in  1  DataMem completion strobe.

Behaviour:
- Address split: offset = cpu_addr[1:0], index = cpu_addr[INDEX_W+1:2], tag = remaining upper bits. Hit = valid[index] && tag_ram[index]==tag.
- Reset (asynchronous, rst_n=0): state=IDLE; all valid bits=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, stall=0. Reset mid-transaction abandons the request; DataMem outputs are ignored until the next request.
- Tag and data storage are not reset; only the valid bits are.
- States: IDLE, RD_MISS, WR_THRU, FILL.
- IDLE, cpu_read with hit: cpu_rdata = line word[offset] combinationally, stall=0, zero extra latency.
- IDLE, cpu_read with miss: stall=1 in the same cycle. Latch address. mem_read=1, mem_addr={tag,index,2'b00} from the next edge. Go to RD_MISS.
- IDLE, cpu_write (hit or miss): stall=1. Latch address and data. mem_write=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata. Go to WR_THRU.
- cpu_read and cpu_write both high: treated as a write; cpu_rdata is don't-care.
- RD_MISS: hold mem_read, mem_addr, and stall. On the first posedge with mem_ready=1: write mem_block into line[index], set tag and valid, drop mem_read, go to FILL.
- FILL: one cycle; stall=1; go to IDLE. The held request then hits. Read-miss penalty = DataMem latency + 2 cycles.
- WR_THRU: hold mem_write, mem_addr, mem_wdata, and stall. On mem_ready=1: if the latched address hits, update only word[offset] of the line; a miss does not allocate. Drop mem_write and go to IDLE. stall falls in IDLE.
- Latched copies drive memory-side outputs. CPU-side changes during stall do not disturb the in-flight transaction.
- mem_read and mem_write are never high simultaneously.
- mem_ready while in IDLE or FILL is ignored.
- Index wrap: the address 10'h3FF maps to index 15, offset 3; no special case.
- A conflicting tag on the same index replaces the line on a read miss.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0], reset to 0.
  - Each accepted CPU request increments exactly one counter when it leaves IDLE or completes as a hit.
  - A read hit counts as a hit.
  - A read miss counts as a miss once; its replay after FILL is not counted.
  - A write hit or write miss counts by tag match at the time of acceptance.
  - Counters saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with rst_n=0, then cpu_read at addr 5: miss → mem_read=1, mem_addr=4. After mem_ready, stall drops and cpu_rdata equals mem_block word 1.
- Read addr 5, then addr 6 with no intervening write: the second read is a hit. stall=0 in the same cycle, mem_read stays 0, cpu_rdata = block word 2.
- Write 8 to addr 5 after the fill: mem_write=1, mem_addr=5, mem_wdata=8 until mem_ready. A following read of addr 5 hits and returns 8.
- Write 32'hDEAD to addr 3 with the line invalid: write-through only. A following read of addr 3 misses and issues mem_read with mem_addr=0.
- Read addr 5 (fill), then read addr 69 (same index 1, tag 1): miss and replacement. A read of addr 5 then misses again.
- Assert rst_n=0 while in RD_MISS: mem_read=0 and stall=0 immediately. All lines are invalid afterwards. With DCACHE_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller in front of a
// block-oriented DataMem. Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned INDEX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              stall,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [127:0]      mem_block,
   input  logic              mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
   localparam int unsigned LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru, StFill} state_e;

   state_e              state_q, state_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [31:0]         data_q [LINES][4];
   logic [ADDR_W-1:0]   lat_addr_q;
   logic                mem_read_q, mem_write_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;

   logic [TAG_W-1:0]    cpu_tag, lat_tag;
   logic [INDEX_W-1:0]  cpu_index, lat_index;
   logic [1:0]          cpu_off, lat_off;
   logic                cpu_hit, lat_hit;
   logic                accept_rd, accept_wr, fill_en, wr_done, wr_upd;

   assign cpu_tag   = cpu_addr[ADDR_W-1:INDEX_W+2];
   assign cpu_index = cpu_addr[INDEX_W+1:2];
   assign cpu_off   = cpu_addr[1:0];
   assign lat_tag   = lat_addr_q[ADDR_W-1:INDEX_W+2];
   assign lat_index = lat_addr_q[INDEX_W+1:2];
   assign lat_off   = lat_addr_q[1:0];
   assign cpu_hit   = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
   assign lat_hit   = valid_q[lat_index] && (tag_q[lat_index] == lat_tag);

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      cpu_rdata = '0;
      accept_rd = 1'b0;
      accept_wr = 1'b0;
      fill_en   = 1'b0;
      wr_done   = 1'b0;
      wr_upd    = 1'b0;
      case (state_q)
         StIdle: begin
            // A simultaneous read and write is treated as a write.
            if (cpu_write) begin
               stall     = 1'b1;
               accept_wr = 1'b1;
               state_d   = StWrThru;
            end else if (cpu_read) begin
               if (cpu_hit) begin
                  cpu_rdata = data_q[cpu_index][cpu_off];
               end else begin
                  stall     = 1'b1;
                  accept_rd = 1'b1;
                  state_d   = StRdMiss;
               end
            end
         end
         StRdMiss: begin
            stall = 1'b1;
            if (mem_ready) begin
               fill_en = 1'b1;
               state_d = StFill;
            end
         end
         StFill: begin
            stall   = 1'b1;
            state_d = StIdle;
         end
         StWrThru: begin
            stall = 1'b1;
            if (mem_ready) begin
               wr_done = 1'b1;
               wr_upd  = lat_hit;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // CPU-facing outputs read as idle while reset is held.
      if (!rst_n) begin
         stall     = 1'b0;
         cpu_rdata = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         lat_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_rd) begin
            lat_addr_q <= cpu_addr;
            mem_read_q <= 1'b1;
            mem_addr_q <= {cpu_addr[ADDR_W-1:2], 2'b00};
         end
         if (accept_wr) begin
            lat_addr_q  <= cpu_addr;
            mem_write_q <= 1'b1;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
         end
         if (fill_en) begin
            mem_read_q         <= 1'b0;
            valid_q[lat_index] <= 1'b1;
         end
         if (wr_done) begin
            mem_write_q <= 1'b0;
         end
      end
   end

   // Line storage is deliberately not reset; the valid bits guard it.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[lat_index] <= lat_tag;
         for (int k = 0; k < 4; k++) begin
            data_q[lat_index][k] <= mem_block[32*k +: 32];
         end
      end
      if (wr_upd) begin
         data_q[lat_index][lat_off] <= mem_wdata_q;
      end
   end

`ifdef DCACHE_STATS_EN
   logic replay_q, hit_ev, miss_ev;

   always_comb begin
      hit_ev  = 1'b0;
      miss_ev = 1'b0;
      if (state_q == StIdle) begin
         if (cpu_write) begin
            hit_ev  = cpu_hit;
            miss_ev = !cpu_hit;
         end else if (cpu_read) begin
            // The replayed read right after a fill was already counted as a miss.
            hit_ev  = cpu_hit && !replay_q;
            miss_ev = !cpu_hit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         replay_q   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         replay_q <= (state_q == StFill);
         if (hit_ev && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
         end
         if (miss_ev && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl; DataMem responses are driven by hand
// with a one-cycle wait before mem_ready.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cpu_read, cpu_write;
   logic [9:0]   cpu_addr;
   logic [31:0]  cpu_wdata, cpu_rdata;
   logic         stall, mem_read, mem_write;
   logic [9:0]   mem_addr;
   logic [31:0]  mem_wdata;
   logic [127:0] mem_block;
   logic         mem_ready;
`ifdef DCACHE_STATS_EN
   logic [15:0]  hit_count, miss_count;
`endif

   int checks   = 0;
   int failures = 0;

   dcache_ctrl #(
      .ADDR_W  (10),
      .INDEX_W (4)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_block (mem_block),
      .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Read miss: checks request, one wait cycle, fill, and the replayed hit.
   task automatic read_miss(input logic [9:0] addr, input logic [127:0] blk, input string tag);
      logic [31:0] exp_word;
      exp_word  = blk[32*addr[1:0] +: 32];
      cpu_read  = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = addr;
      #1;
      check({tag, "_stall_now"}, {31'd0, stall}, 32'd1);
      step();
      check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd1);
      check({tag, "_mem_addr"}, {22'd0, mem_addr}, {22'd0, addr[9:2], 2'b00});
      step();
      check({tag, "_hold"}, {31'd0, mem_read & stall}, 32'd1);
      mem_block = blk;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      mem_block = '0;
      check({tag, "_fill_rd"}, {31'd0, mem_read}, 32'd0);
      check({tag, "_fill_stall"}, {31'd0, stall}, 32'd1);
      step();
      check({tag, "_replay_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_replay_data"}, cpu_rdata, exp_word);
      step();
   endtask

   task automatic write_thru(input logic [9:0] addr, input logic [31:0] data, input string tag);
      cpu_read  = 1'b0;
      cpu_write = 1'b1;
      cpu_addr  = addr;
      cpu_wdata = data;
      #1;
      check({tag, "_stall_now"}, {31'd0, stall}, 32'd1);
      step();
      check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd1);
      check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
      check({tag, "_mem_addr"}, {22'd0, mem_addr}, {22'd0, addr});
      // CPU-side changes must not disturb the in-flight store.
      cpu_addr  = 10'h2AA;
      cpu_wdata = 32'hBAD0_BAD0;
      step();
      check({tag, "_mem_wdata"}, mem_wdata, data);
      check({tag, "_mem_addr_held"}, {22'd0, mem_addr}, {22'd0, addr});
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check({tag, "_done"}, {31'd0, mem_write}, 32'd0);
      cpu_write = 1'b0;
      #1;
      check({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
   endtask

   logic [127:0] blk_a, blk_b, blk_c;

   initial begin
      blk_a = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      blk_b = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
      blk_c = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
      rst_n     = 1'b0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_block = '0;
      mem_ready = 1'b0;
      #12;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      read_miss(10'd5, blk_a, "rd5");

      cpu_addr = 10'd6;
      #1;
      check("hit6_stall", {31'd0, stall}, 32'd0);
      check("hit6_data", cpu_rdata, 32'hA000_0002);
      step();
      check("hit6_no_mem", {31'd0, mem_read}, 32'd0);

      write_thru(10'd5, 32'd8, "wr5");
      cpu_read = 1'b1;
      cpu_addr = 10'd5;
      #1;
      check("rd5_after_wr_stall", {31'd0, stall}, 32'd0);
      check("rd5_after_wr_data", cpu_rdata, 32'd8);
      step();

      write_thru(10'd3, 32'hDEAD, "wr3");
      read_miss(10'd3, blk_b, "rd3");

      cpu_addr = 10'd5;
      #1;
      check("rd5_still_hit", cpu_rdata, 32'd8);
      step();

      read_miss(10'd69, blk_c, "rd69");
      cpu_addr = 10'd5;
      #1;
      check("rd5_evicted_stall", {31'd0, stall}, 32'd1);
      step();
      check("rd5_evicted_mem_read", {31'd0, mem_read}, 32'd1);
      check("rd5_evicted_mem_addr", {22'd0, mem_addr}, 32'd4);
`ifdef DCACHE_STATS_EN
      check("stats_hit", {16'd0, hit_count}, 32'd4);
      check("stats_miss", {16'd0, miss_count}, 32'd5);
`endif

      rst_n = 1'b0;
      #1;
      check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
      check("midrst_stall", {31'd0, stall}, 32'd0);
      check("midrst_mem_addr", {22'd0, mem_addr}, 32'd0);
`ifdef DCACHE_STATS_EN
      check("midrst_hit_count", {16'd0, hit_count}, 32'd0);
      check("midrst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
      step();
      rst_n = 1'b1;
      #1;
      check("postrst_rd5_miss", {31'd0, stall}, 32'd1);
      cpu_addr = 10'd3;
      #1;
      check("postrst_rd3_miss", {31'd0, stall}, 32'd1);
      cpu_read = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
